alu_seq_core: RTL and testbench
===============================

ALU_SEQ_CORE -- requirements
Module: alu_seq_core

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits; legal range 4..32, even.
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount width taken from datab[SHW-1:0].
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_a  input  1  reset, synchronous, active-high.
REQ-005 dataa  input  WIDTH  operand A, sampled only on an accepted start.
REQ-006 datab  input  WIDTH  operand B, sampled only on an accepted start.
REQ-007 opcode  input  4  operation select, sampled only on an accepted start.
REQ-008 start  input  1  request; accepted only when busy=0.
REQ-009 out  output  2*WIDTH  registered result; held until the next completion.
REQ-010 carry_flag  output  1  carry/borrow/high-half-nonzero, by opcode.
REQ-011 zero_flag  output  1  high when out==0.
REQ-012 overflow_flag  output  1  signed overflow for ADD/SUB; 0 otherwise.
REQ-013 error_flag  output  1  high when the completed opcode was illegal.
REQ-014 done_flag  output  1  one-cycle pulse marking out/flags updated.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, EXEC, MUL, DONE; IDLE->EXEC on start with busy=0, latching operands and opcode.
REQ-017 EXEC SHALL go to MUL for opcode 8, otherwise to DONE; DONE SHALL return to IDLE unconditionally after one cycle.
REQ-018 Opcodes: 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 SHL A by B[SHW-1:0], 7 SHR logical, 8 MUL unsigned; 9-15 illegal.
REQ-019 Opcodes 0-7 SHALL write out[WIDTH-1:0] with the result and out[2*WIDTH-1:WIDTH] with 0.
REQ-020 ADD carry_flag SHALL equal the carry out of bit WIDTH-1; SUB carry_flag SHALL equal 1 when A<B unsigned (borrow).
REQ-021 MUL SHALL use shift-add, one partial product per cycle, WIDTH cycles in MUL, writing the full 2*WIDTH product; carry_flag = |out[2*WIDTH-1:WIDTH].
REQ-022 Logic and shift ops SHALL clear carry_flag and overflow_flag.
REQ-023 Illegal opcodes SHALL produce out=0, error_flag=1, zero_flag=1, and all other flags 0; a legal completion SHALL clear error_flag.
REQ-024 Latency: with start accepted at edge N, done_flag SHALL be high for exactly the cycle after edge N+2 (ops 0-7, illegal) or N+WIDTH+2 (MUL).
REQ-025 out and flags SHALL change only at the edge that raises done_flag.
REQ-026 start while busy=1 SHALL be ignored, with no queuing.
REQ-027 start held high continuously SHALL trigger one new operation per return to IDLE; busy low for one cycle between back-to-back operations.
REQ-028 Operand inputs changing while busy SHALL not affect the result.

Reset
REQ-029 reset_a=1 at an edge SHALL force IDLE and clear out, all flags, done_flag, busy and internal multiplier state, regardless of current state (aborts MUL mid-run; no done_flag).
REQ-030 start coincident with reset_a SHALL be ignored.

Structure
REQ-031 Opcode encodings and FSM state encodings SHALL be constants in shared package alu_pkg.
REQ-032 The shift-add multiplier SHALL be a sub-module alu_mul_seq (WIDTH parameter, load/step/product ports); the datapath and FSM remain in alu_seq_core.

Verification (WIDTH=16)
REQ-033 ADD 0xFFFF+0x0001 -> out=0x00000000, carry=1, zero=1, overflow=0, done at N+2.
REQ-034 SUB 0x0003-0x0005 -> out=0x0000FFFE, carry=1, zero=0; SUB 0x8000-0x0001 -> overflow=1.
REQ-035 MUL 0xFFFF*0xFFFF -> out=0xFFFE0001, carry=1, done at N+18; busy high 18 cycles.
REQ-036 start with ADD issued at N+3 during a MUL -> ignored; only the MUL result appears, single done pulse.
REQ-037 reset_a at N+8 during MUL -> out=0, busy=0 at next edge, no done_flag; next ADD 2+3 -> 0x00000005.
REQ-038 opcode 0xF -> out=0, error_flag=1, zero=1 at N+2; following AND 0x00F0&0x0FF0 -> 0x000000F0, error_flag=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the sequential ALU: opcode encodings and FSM states.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add unsigned multiplier: one partial product per step.
// The low half of the accumulator holds the remaining multiplier bits; each step
// conditionally adds the multiplicand into the high half and shifts right by one,
// so after WIDTH steps the accumulator holds the full product.
module alu_mul_seq #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset_a,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic [2*WIDTH-1:0] product
);

    logic [WIDTH-1:0]   mcand_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [WIDTH:0]     sum_next;

    // High half plus the multiplicand when the current multiplier bit is set
    assign sum_next = {1'b0, acc_reg[2*WIDTH-1:WIDTH]}
                    + (acc_reg[0] ? {1'b0, mcand_reg} : '0);

    // Load operands, then accumulate-and-shift once per step
    always_ff @(posedge clk) begin
        if (reset_a) begin
            mcand_reg <= '0;
            acc_reg   <= '0;
        end else if (load) begin
            mcand_reg <= multiplicand;
            acc_reg   <= {{WIDTH{1'b0}}, multiplier};
        end else if (step) begin
            acc_reg   <= {sum_next, acc_reg[WIDTH-1:1]};
        end
    end

    assign product = acc_reg;

endmodule

// File: rtl/alu_seq_core.sv
// Sequential ALU core: IDLE -> EXEC -> (MUL) -> DONE -> IDLE.
// Operands are captured on an accepted start; results and flags are written
// only on the DONE->IDLE edge, which also raises the one-cycle done pulse.
module alu_seq_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               reset_a,
    input  logic [WIDTH-1:0]   dataa,
    input  logic [WIDTH-1:0]   datab,
    input  logic [3:0]         opcode,
    input  logic               start,
    output logic [2*WIDTH-1:0] out,
    output logic               carry_flag,
    output logic               zero_flag,
    output logic               overflow_flag,
    output logic               error_flag,
    output logic               done_flag,
    output logic               busy
);

    localparam int CW = $clog2(WIDTH);

    state_t             state_reg;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [3:0]         op_reg;
    logic [CW-1:0]      cnt_reg;
    logic [2*WIDTH-1:0] out_reg;
    logic               carry_reg;
    logic               zero_reg;
    logic               ovf_reg;
    logic               err_reg;
    logic               done_reg;
    logic               busy_reg;

    logic [WIDTH:0]     sum_ext;
    logic [WIDTH:0]     dif_ext;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] res_next;
    logic               carry_next;
    logic               ovf_next;
    logic               err_next;
    logic               mul_load;
    logic               mul_step;

    assign sum_ext  = {1'b0, a_reg} + {1'b0, b_reg};
    assign dif_ext  = {1'b0, a_reg} - {1'b0, b_reg};
    assign mul_load = (state_reg == ST_EXEC) && (op_reg == OP_MUL);
    assign mul_step = (state_reg == ST_MUL);

    alu_mul_seq #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk          (clk),
        .reset_a      (reset_a),
        .load         (mul_load),
        .step         (mul_step),
        .multiplicand (a_reg),
        .multiplier   (b_reg),
        .product      (product)
    );

    // Result and flag selection from the latched operands and opcode
    always_comb begin
        res_next   = '0;
        carry_next = 1'b0;
        ovf_next   = 1'b0;
        err_next   = 1'b0;
        case (op_reg)
            OP_ADD: begin
                res_next[WIDTH-1:0] = sum_ext[WIDTH-1:0];
                carry_next          = sum_ext[WIDTH];
                ovf_next            = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                                      (sum_ext[WIDTH-1] != a_reg[WIDTH-1]);
            end
            OP_SUB: begin
                res_next[WIDTH-1:0] = dif_ext[WIDTH-1:0];
                carry_next          = dif_ext[WIDTH];
                ovf_next            = (a_reg[WIDTH-1] != b_reg[WIDTH-1]) &&
                                      (dif_ext[WIDTH-1] != a_reg[WIDTH-1]);
            end
            OP_AND: res_next[WIDTH-1:0] = a_reg & b_reg;
            OP_OR:  res_next[WIDTH-1:0] = a_reg | b_reg;
            OP_XOR: res_next[WIDTH-1:0] = a_reg ^ b_reg;
            OP_NOT: res_next[WIDTH-1:0] = ~a_reg;
            OP_SHL: res_next[WIDTH-1:0] = a_reg << b_reg[SHW-1:0];
            OP_SHR: res_next[WIDTH-1:0] = a_reg >> b_reg[SHW-1:0];
            OP_MUL: begin
                res_next   = product;
                carry_next = |product[2*WIDTH-1:WIDTH];
            end
            default: err_next = 1'b1;
        endcase
    end

    // Control FSM with registered outputs
    always_ff @(posedge clk) begin
        if (reset_a) begin
            state_reg <= ST_IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            op_reg    <= '0;
            cnt_reg   <= '0;
            out_reg   <= '0;
            carry_reg <= 1'b0;
            zero_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
            err_reg   <= 1'b0;
            done_reg  <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        a_reg     <= dataa;
                        b_reg     <= datab;
                        op_reg    <= opcode;
                        busy_reg  <= 1'b1;
                        state_reg <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    cnt_reg   <= '0;
                    state_reg <= (op_reg == OP_MUL) ? ST_MUL : ST_DONE;
                end
                ST_MUL: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == CW'(WIDTH - 1)) begin
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    out_reg   <= res_next;
                    carry_reg <= carry_next;
                    zero_reg  <= (res_next == '0);
                    ovf_reg   <= ovf_next;
                    err_reg   <= err_next;
                    done_reg  <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign out           = out_reg;
    assign carry_flag    = carry_reg;
    assign zero_flag     = zero_reg;
    assign overflow_flag = ovf_reg;
    assign error_flag    = err_reg;
    assign done_flag     = done_reg;
    assign busy          = busy_reg;

endmodule

// File: tb/tb_alu_seq_core.sv
// Directed bench for alu_seq_core at WIDTH=16.
module tb_alu_seq_core;

    logic        clk = 1'b0;
    logic        reset_a = 1'b1;
    logic [15:0] dataa = '0;
    logic [15:0] datab = '0;
    logic [3:0]  opcode = '0;
    logic        start = 1'b0;
    logic [31:0] out;
    logic        carry_flag, zero_flag, overflow_flag, error_flag, done_flag, busy;

    int checks = 0;
    int failures = 0;

    alu_seq_core #(.WIDTH(16)) dut (
        .clk           (clk),
        .reset_a       (reset_a),
        .dataa         (dataa),
        .datab         (datab),
        .opcode        (opcode),
        .start         (start),
        .out           (out),
        .carry_flag    (carry_flag),
        .zero_flag     (zero_flag),
        .overflow_flag (overflow_flag),
        .error_flag    (error_flag),
        .done_flag     (done_flag),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // flags packed as {carry, zero, overflow, error}
    function automatic logic [3:0] flags();
        return {carry_flag, zero_flag, overflow_flag, error_flag};
    endfunction

    // ALU op vectors: opcode, A, B, expected out, expected {c,z,v,e}
    localparam int NV = 15;
    logic [3:0]  v_op  [NV] = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2, 4'd3, 4'd4,
                                4'd5, 4'd6, 4'd7, 4'd6, 4'd15, 4'd2, 4'd9};
    logic [15:0] v_a   [NV] = '{16'hFFFF, 16'h7FFF, 16'h0003, 16'h8000, 16'h0005,
                                16'h00F0, 16'h00F0, 16'hFF00, 16'h00FF, 16'h0001,
                                16'h8000, 16'h8000, 16'h1234, 16'h00F0, 16'h0000};
    logic [15:0] v_b   [NV] = '{16'h0001, 16'h0001, 16'h0005, 16'h0001, 16'h0005,
                                16'h0FF0, 16'h0F00, 16'h0FF0, 16'h5A5A, 16'h0013,
                                16'h000F, 16'h0001, 16'h5678, 16'h0FF0, 16'h0000};
    logic [31:0] v_out [NV] = '{32'h0, 32'h8000, 32'hFFFE, 32'h7FFF, 32'h0,
                                32'h00F0, 32'h0FF0, 32'hF0F0, 32'hFF00, 32'h0008,
                                32'h0001, 32'h0, 32'h0, 32'h00F0, 32'h0};
    logic [3:0]  v_fl  [NV] = '{4'b1100, 4'b0010, 4'b1000, 4'b0010, 4'b0100,
                                4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                                4'b0000, 4'b0100, 4'b0101, 4'b0000, 4'b0101};

    localparam int NM = 4;
    logic [15:0] m_a   [NM] = '{16'hFFFF, 16'h0003, 16'h1234, 16'h0000};
    logic [15:0] m_b   [NM] = '{16'hFFFF, 16'h0005, 16'h0100, 16'hABCD};
    logic [31:0] m_out [NM] = '{32'hFFFE0001, 32'h0000000F, 32'h00123400, 32'h0};
    logic [3:0]  m_fl  [NM] = '{4'b1000, 4'b0000, 4'b1000, 4'b0100};

    // Issue one operation (start accepted at edge N) and wait for done.
    // lat = edges after N at which done was seen (-1 on timeout); operands
    // are scrambled right after acceptance.
    task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                          output int lat, output int busy_n);
        @(negedge clk);
        opcode = op; dataa = a; datab = b; start = 1'b1;
        @(posedge clk);
        lat = -1;
        busy_n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 0) begin
                start = 1'b0; dataa = ~a; datab = a ^ b; opcode = 4'd3;
            end
            if (done_flag) begin
                lat = k;
                break;
            end
            if (busy) busy_n++;
        end
    endtask

    task automatic test_reset();
        reset_a = 1'b1;
        start = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({out, flags(), done_flag, busy} !== 38'h0) begin
            failures++;
            $display("FAIL reset_state: out=%h flags=%b done=%b busy=%b required all zero",
                     out, flags(), done_flag, busy);
        end
        start = 1'b0;
        reset_a = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_start_ignored: busy=%b required 0", busy);
        end
        $display("reset: out=%h busy=%b", out, busy);
    endtask

    task automatic test_alu_ops();
        int lat, bn;
        for (int i = 0; i < NV; i++) begin
            run_op(v_op[i], v_a[i], v_b[i], lat, bn);
            checks++;
            if (lat !== 2 || bn !== 2) begin
                failures++;
                $display("FAIL alu_latency[%0d]: lat=%0d busy=%0d required 2/2", i, lat, bn);
            end
            checks++;
            if (out !== v_out[i] || flags() !== v_fl[i]) begin
                failures++;
                $display("FAIL alu_result[%0d]: op=%0d out=%h flags=%b required out=%h flags=%b",
                         i, v_op[i], out, flags(), v_out[i], v_fl[i]);
            end
            @(negedge clk);
            checks++;
            if (done_flag !== 1'b0 || out !== v_out[i]) begin
                failures++;
                $display("FAIL alu_done_pulse[%0d]: done=%b out=%h required 0/%h",
                         i, done_flag, out, v_out[i]);
            end
            $display("alu op=%0d a=%h b=%h -> out=%h flags=%b lat=%0d", v_op[i], v_a[i], v_b[i],
                     out, flags(), lat);
        end
    endtask

    task automatic test_mul();
        int lat, bn;
        for (int i = 0; i < NM; i++) begin
            run_op(4'd8, m_a[i], m_b[i], lat, bn);
            checks++;
            if (lat !== 18 || bn !== 18) begin
                failures++;
                $display("FAIL mul_latency[%0d]: lat=%0d busy=%0d required 18/18", i, lat, bn);
            end
            checks++;
            if (out !== m_out[i] || flags() !== m_fl[i]) begin
                failures++;
                $display("FAIL mul_result[%0d]: out=%h flags=%b required out=%h flags=%b",
                         i, out, flags(), m_out[i], m_fl[i]);
            end
            $display("mul a=%h b=%h -> out=%h flags=%b lat=%0d", m_a[i], m_b[i], out, flags(), lat);
        end
    endtask

    task automatic test_busy_ignore();
        int dones = 0;
        int first_k = -1;
        @(negedge clk);
        opcode = 4'd8; dataa = 16'h0002; datab = 16'h0003; start = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
            if (k == 2) begin
                start = 1'b1; opcode = 4'd0; dataa = 16'h0010; datab = 16'h0020;
            end
            if (k == 3) start = 1'b0;
            if (done_flag) begin
                dones++;
                if (first_k < 0) first_k = k;
            end
        end
        checks++;
        if (dones !== 1 || first_k !== 18) begin
            failures++;
            $display("FAIL busy_ignore_done: pulses=%0d at=%0d required 1 at 18", dones, first_k);
        end
        checks++;
        if (out !== 32'h6 || busy !== 1'b0) begin
            failures++;
            $display("FAIL busy_ignore_result: out=%h busy=%b required 00000006/0", out, busy);
        end
        $display("busy_ignore: out=%h pulses=%0d", out, dones);
    endtask

    task automatic test_reset_mid_mul();
        int dones = 0;
        int lat, bn;
        @(negedge clk);
        opcode = 4'd8; dataa = 16'hFFFF; datab = 16'hFFFF; start = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
            if (k == 5) begin
                checks++;
                if (out !== 32'h6 || busy !== 1'b1) begin
                    failures++;
                    $display("FAIL mul_out_held: out=%h busy=%b required 00000006/1", out, busy);
                end
            end
            if (k == 7) begin
                reset_a = 1'b1;
                start = 1'b1; opcode = 4'd0; dataa = 16'h0001; datab = 16'h0001;
            end
        end
        @(negedge clk);
        reset_a = 1'b0;
        start = 1'b0;
        checks++;
        if (out !== 32'h0 || busy !== 1'b0 || done_flag !== 1'b0 || flags() !== 4'b0) begin
            failures++;
            $display("FAIL reset_abort: out=%h busy=%b done=%b flags=%b required 0/0/0/0000",
                     out, busy, done_flag, flags());
        end
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (done_flag || busy) dones++;
        end
        checks++;
        if (dones !== 0) begin
            failures++;
            $display("FAIL reset_no_done: active_cycles=%0d required 0", dones);
        end
        run_op(4'd0, 16'h0002, 16'h0003, lat, bn);
        checks++;
        if (out !== 32'h5 || lat !== 2) begin
            failures++;
            $display("FAIL post_reset_add: out=%h lat=%0d required 00000005/2", out, lat);
        end
        $display("reset_mid_mul: post-reset add out=%h", out);
    endtask

    task automatic test_back_to_back();
        int dones = 0;
        @(negedge clk);
        opcode = 4'd0; dataa = 16'h0001; datab = 16'h0002; start = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) begin
                dataa = 16'h000A; datab = 16'h0014;
            end
            if (done_flag) dones++;
            if (k == 2) begin
                checks++;
                if (done_flag !== 1'b1 || out !== 32'h3 || busy !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_first: done=%b out=%h busy=%b required 1/00000003/0",
                             done_flag, out, busy);
                end
            end
            if (k == 3) begin
                checks++;
                if (busy !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_restart: busy=%b required 1", busy);
                end
                start = 1'b0;
            end
            if (k == 5) begin
                checks++;
                if (done_flag !== 1'b1 || out !== 32'h1E) begin
                    failures++;
                    $display("FAIL b2b_second: done=%b out=%h required 1/0000001e", done_flag, out);
                end
            end
        end
        checks++;
        if (dones !== 2) begin
            failures++;
            $display("FAIL b2b_pulses: pulses=%0d required 2", dones);
        end
        $display("back_to_back: pulses=%0d last out=%h", dones, out);
    endtask

    initial begin
        test_reset();
        test_alu_ops();
        test_mul();
        test_busy_ignore();
        test_reset_mid_mul();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
